// File: rtl/controlador_saida_pkg.sv
// saida_pkg: shared state encoding, default data width and index-width helper for controlador_saida.
// Imported by the arbiter and the output-path controller.
package saida_pkg;

    typedef enum logic [1:0] {OCIOSO, ESCRITA, ESPERA} estado_t;

    localparam int DATA_W_PADRAO = 32;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/controlador_saida_arbitro_rr.sv
// arbitro_rr: combinational winner select; round-robin from ptr+1 with wrap,
// or lowest-index-wins when SAIDA_PRIORIDADE_FIXA_EN is defined (no pointer port then).
module arbitro_rr
    import saida_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifndef SAIDA_PRIORIDADE_FIXA_EN
    input  logic [IW-1:0]      ptr,
`endif
    output logic [NUM_REQ-1:0] grant,
    output logic [IW-1:0]      idx,
    output logic               valid
);

`ifdef SAIDA_PRIORIDADE_FIXA_EN
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req[i]) idx = IW'(i);
    end
`else
    logic [IW-1:0] k;

    // Scan downward so the candidate closest to ptr+1 is assigned last and wins.
    always_comb begin
        idx = '0;
        k   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            k = IW'((int'(ptr) + i) % NUM_REQ);
            if (req[k]) idx = k;
        end
    end
`endif

    assign valid = |req;
    assign grant = valid ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/controlador_saida.sv
// controlador_saida: shares the output register / display path among NUM_REQ requesters
// with req/ack handshake and a minimum hold time; SAIDA_PRIORIDADE_FIXA_EN selects fixed priority.
module controlador_saida
    import saida_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DATA_W_PADRAO,
    parameter int HOLD_CYCLES = 0,
    localparam int IW = idx_w(NUM_REQ)
) (
    input  logic                      CLK,
    input  logic                      RST_n,
    input  logic [NUM_REQ-1:0]        Req,
    input  logic [NUM_REQ*DATA_W-1:0] Dado,
    output logic [NUM_REQ-1:0]        Ack,
    output logic [DATA_W-1:0]         DadoEntrada,
    output logic                      CTRLSaida,
    output logic [IW-1:0]             Fonte,
    output logic                      Ocupado
);

    localparam int CW = 20;

    estado_t             st, nxt;
    logic [CW-1:0]       cnt;
    logic [NUM_REQ-1:0]  grant;
    logic [IW-1:0]       idx;
    logic                valid;

`ifdef SAIDA_PRIORIDADE_FIXA_EN
    arbitro_rr #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(Req), .grant(grant), .idx(idx), .valid(valid)
    );
`else
    logic [IW-1:0] ptr;

    arbitro_rr #(.NUM_REQ(NUM_REQ)) u_arb (
        .req(Req), .ptr(ptr), .grant(grant), .idx(idx), .valid(valid)
    );

    // Reset to the last index so requester 0 is the first round-robin winner.
    always_ff @(posedge CLK or negedge RST_n)
        if (!RST_n) ptr <= IW'(NUM_REQ - 1);
        else if (st == OCIOSO && valid) ptr <= idx;
`endif

    always_comb begin
        nxt = st;
        case (st)
            OCIOSO:  nxt = valid ? ESCRITA : OCIOSO;
            ESCRITA: nxt = (HOLD_CYCLES > 0) ? ESPERA : OCIOSO;
            ESPERA:  nxt = (cnt == '0) ? OCIOSO : ESPERA;
            default: nxt = OCIOSO;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            st          <= OCIOSO;
            cnt         <= '0;
            Ack         <= '0;
            CTRLSaida   <= 1'b0;
            DadoEntrada <= '0;
            Fonte       <= '0;
        end else begin
            st        <= nxt;
            Ack       <= '0;
            CTRLSaida <= 1'b0;
            if (st == OCIOSO && valid) begin
                DadoEntrada <= Dado[int'(idx)*DATA_W +: DATA_W];
                Ack         <= grant;
                CTRLSaida   <= 1'b1;
                Fonte       <= idx;
            end
            if (st == ESCRITA) cnt <= CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
            else if (st == ESPERA && cnt != '0) cnt <= cnt - 1'b1;
        end
    end

    assign Ocupado = (st != OCIOSO);

endmodule

// File: tb/tb_controlador_saida.sv
// tb_controlador_saida: directed checks on two instances (HOLD_CYCLES=0 and HOLD_CYCLES=5).
// Inputs change and outputs are sampled just after the falling edge.
module tb_controlador_saida;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req0 = '0, req5 = '0;
    logic [127:0] d0 = '0, d5 = '0;
    logic [3:0]   ack0, ack5;
    logic [31:0]  de0, de5;
    logic         ct0, ct5, oc0, oc5;
    logic [1:0]   f0, f5;
    int           checks = 0, errors = 0;

    always #5 clk = ~clk;

    controlador_saida #(.NUM_REQ(4), .DATA_W(32), .HOLD_CYCLES(0)) u0 (
        .CLK(clk), .RST_n(rst_n), .Req(req0), .Dado(d0), .Ack(ack0),
        .DadoEntrada(de0), .CTRLSaida(ct0), .Fonte(f0), .Ocupado(oc0)
    );

    controlador_saida #(.NUM_REQ(4), .DATA_W(32), .HOLD_CYCLES(5)) u5 (
        .CLK(clk), .RST_n(rst_n), .Req(req5), .Dado(d5), .Ack(ack5),
        .DadoEntrada(de5), .CTRLSaida(ct5), .Fonte(f5), .Ocupado(oc5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_ack0", 64'(ack0), 64'h0);
        chk("rst_ct0", 64'(ct0), 64'h0);
        chk("rst_de0", 64'(de0), 64'h0);
        chk("rst_f0", 64'(f0), 64'h0);
        chk("rst_oc0", 64'(oc0), 64'h0);
        nclk(2);
        rst_n = 1'b1;

        // test 1: single request
        req0 = 4'b0001;
        d0[31:0] = 32'd1234;
        nclk(1);
        chk("t1_ack", 64'(ack0), 64'h1);
        chk("t1_ct", 64'(ct0), 64'h1);
        chk("t1_de", 64'(de0), 64'd1234);
        chk("t1_f", 64'(f0), 64'h0);
        chk("t1_oc", 64'(oc0), 64'h1);
        req0 = 4'b0000;
        nclk(1);
        chk("t1_ack_off", 64'(ack0), 64'h0);
        chk("t1_ct_off", 64'(ct0), 64'h0);
        chk("t1_oc_off", 64'(oc0), 64'h0);
        chk("t1_de_hold", 64'(de0), 64'd1234);

        // test 2: four requesters, rotation from 0 after a fresh reset
        rst_n = 1'b0;
        #1;
        chk("t2_rst_de", 64'(de0), 64'h0);
        nclk(1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) d0[i*32 +: 32] = 32'(100 + i);
        req0 = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            nclk(1);
            chk($sformatf("t2_ack%0d", k), 64'(ack0), 64'(4'b0001 << k));
            chk($sformatf("t2_ct%0d", k), 64'(ct0), 64'h1);
            chk($sformatf("t2_de%0d", k), 64'(de0), 64'(100 + k));
            chk($sformatf("t2_f%0d", k), 64'(f0), 64'(k));
            req0[k] = 1'b0;
            nclk(1);
            chk($sformatf("t2_gap%0d", k), 64'({ack0, ct0}), 64'h0);
        end

        // test 3: HOLD_CYCLES=5, grants exactly 7 cycles apart
        d5[31:0] = 32'd500;
        d5[63:32] = 32'd501;
        req5 = 4'b0011;
        nclk(1);
        chk("t3_ack0", 64'(ack5), 64'h1);
        chk("t3_de0", 64'(de5), 64'd500);
        req5[0] = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            nclk(1);
            chk($sformatf("t3_busy%0d", c), 64'({oc5, ct5, ack5}), 64'h20);
        end
        nclk(1);
        chk("t3_idle7", 64'({oc5, ct5, ack5}), 64'h0);
        nclk(1);
        chk("t3_ack1", 64'(ack5), 64'h2);
        chk("t3_ct1", 64'(ct5), 64'h1);
        chk("t3_de1", 64'(de5), 64'd501);
        chk("t3_f1", 64'(f5), 64'h1);
        chk("t3_oc1", 64'(oc5), 64'h1);
        req5[1] = 1'b0;

        // test 4: reset during ESPERA with a pending request
        nclk(2);
        d5[95:64] = 32'd502;
        req5 = 4'b0100;
        chk("t4_in_espera", 64'(oc5), 64'h1);
        rst_n = 1'b0;
        #1;
        chk("t4_rst_out", 64'({ack5, ct5, de5, f5, oc5}), 64'h0);
        nclk(1);
        chk("t4_no_ack", 64'({ack5, ct5}), 64'h0);
        rst_n = 1'b1;
        req5 = 4'b0101;
        nclk(1);
        chk("t4_ack", 64'(ack5), 64'h1);
        chk("t4_de", 64'(de5), 64'd500);
        chk("t4_f", 64'(f5), 64'h0);
        req5 = 4'b0000;

        // test 5: request raised and withdrawn entirely inside ESPERA
        nclk(1);
        req5 = 4'b0100;
        nclk(2);
        req5 = 4'b0000;
        nclk(3);
        chk("t5_idle", 64'({oc5, ct5, ack5}), 64'h0);
        nclk(2);
        chk("t5_no_ack", 64'({ct5, ack5}), 64'h0);
        chk("t5_de", 64'(de5), 64'd500);
        chk("t5_f", 64'(f5), 64'h0);

        // test 6: Req=1010 held continuously; u0 pointer is at 3 here
        d0[63:32] = 32'd201;
        d0[127:96] = 32'd203;
        req0 = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            nclk(1);
`ifdef SAIDA_PRIORIDADE_FIXA_EN
            chk($sformatf("t6_ack%0d", k), 64'(ack0), 64'h2);
            chk($sformatf("t6_de%0d", k), 64'(de0), 64'd201);
`else
            chk($sformatf("t6_ack%0d", k), 64'(ack0), (k % 2 == 0) ? 64'h2 : 64'h8);
            chk($sformatf("t6_de%0d", k), 64'(de0), (k % 2 == 0) ? 64'd201 : 64'd203);
`endif
            nclk(1);
            chk($sformatf("t6_gap%0d", k), 64'(ack0), 64'h0);
        end
        req0 = 4'b0000;
        nclk(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
